// File: rtl/ysyx_22040365_wb_arbiter.sv
// ysyx_22040365_wb_arbiter
// Writeback controller for the single-write-port register file.
// NUM_REQ sources compete for the write port. A round-robin arbiter picks
// one source per cycle. The chosen write goes out on registered
// rf_wen/rf_waddr/rf_wdata. A per-register busy scoreboard lets the issue
// stage stall on RAW and WAW hazards against writes that are still pending.
//
// Ports
//   clk, rst_n                      clock and async active-low reset
//   req_valid/req_ready             per-requester handshake (ready is combinational, one-hot or zero)
//   req_waddr/req_wdata             packed per-requester dest address / data
//   rf_wen/rf_waddr/rf_wdata        registered regfile write port
//   iss_valid/iss_rd_en/iss_rd      issuing instruction and its destination
//   rs1_addr/rs2_addr               sources to check
//   rs1_busy/rs2_busy               busy state of the sources
//   iss_ready                       low on a WAW hazard with a pending write
module ysyx_22040365_wb_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_waddr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
   output logic                           rf_wen,
   output logic [ADDR_WIDTH-1:0]          rf_waddr,
   output logic [DATA_WIDTH-1:0]          rf_wdata,
   input  logic                           iss_valid,
   input  logic                           iss_rd_en,
   input  logic [ADDR_WIDTH-1:0]          iss_rd,
   input  logic [ADDR_WIDTH-1:0]          rs1_addr,
   input  logic [ADDR_WIDTH-1:0]          rs2_addr,
   output logic                           rs1_busy,
   output logic                           rs2_busy,
   output logic                           iss_ready
);

   localparam int NREG = 2**ADDR_WIDTH;
   localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PW-1:0]         rr_ptr;
   logic [PW-1:0]         gnt_idx;
   logic                  xfer;
   logic [ADDR_WIDTH-1:0] gnt_addr;
   logic [DATA_WIDTH-1:0] gnt_data;
   logic [NREG-1:0]       busy;
   logic [NREG-1:0]       busy_nxt;
   logic                  iss_set;

   // Round-robin: scan from rr_ptr and take the first valid requester.
   always_comb begin
      int idx;
      logic found;
      req_ready = '0;
      gnt_idx   = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found          = 1'b1;
            req_ready[idx] = 1'b1;
            gnt_idx        = PW'(idx);
         end
      end
   end

   // Some requester is always granted when any is valid.
   assign xfer     = |req_valid;
   assign gnt_addr = req_waddr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign gnt_data = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (xfer) begin
         rr_ptr <= (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Writes to x0 complete the handshake but never reach the regfile.
   // Address and data hold their values while no write is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_wen <= xfer && (gnt_addr != '0);
         if (xfer && (gnt_addr != '0)) begin
            rf_waddr <= gnt_addr;
            rf_wdata <= gnt_data;
         end
      end
   end

   // Scoreboard
   assign iss_ready = !(iss_rd_en && busy[iss_rd]);
   assign iss_set   = iss_valid && iss_rd_en && iss_ready && (iss_rd != '0);
   assign rs1_busy  = busy[rs1_addr];
   assign rs2_busy  = busy[rs2_addr];

   // The clear is applied first, so a set to the same register wins.
   always_comb begin
      busy_nxt = busy;
      if (rf_wen)  busy_nxt[rf_waddr] = 1'b0;
      if (iss_set) busy_nxt[iss_rd]   = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

endmodule

// File: tb/tb_ysyx_22040365_wb_arbiter.sv
module tb_ysyx_22040365_wb_arbiter;
   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 64;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_waddr;
   logic [N*DW-1:0] req_wdata;
   logic            rf_wen;
   logic [AW-1:0]   rf_waddr;
   logic [DW-1:0]   rf_wdata;
   logic            iss_valid, iss_rd_en;
   logic [AW-1:0]   iss_rd, rs1_addr, rs2_addr;
   logic            rs1_busy, rs2_busy, iss_ready;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ysyx_22040365_wb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_waddr(req_waddr), .req_wdata(req_wdata),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .iss_valid(iss_valid), .iss_rd_en(iss_rd_en), .iss_rd(iss_rd),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .iss_ready(iss_ready)
   );

   typedef struct {
      logic [N-1:0]  v;
      logic          iv, ien;
      logic [AW-1:0] ird, r1, r2;
      logic [N-1:0]  e_rdy;
      logic          e_b1, e_b2, e_ir, e_wen;
      logic [AW-1:0] e_wa;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [N-1:0] v, input logic iv, input logic ien, input logic [AW-1:0] ird,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic [N-1:0] e_rdy,
                      input logic e_b1, input logic e_b2, input logic e_ir, input logic e_wen,
                      input logic [AW-1:0] e_wa);
      vec_t t;
      t.v = v; t.iv = iv; t.ien = ien; t.ird = ird; t.r1 = r1; t.r2 = r2;
      t.e_rdy = e_rdy; t.e_b1 = e_b1; t.e_b2 = e_b2; t.e_ir = e_ir; t.e_wen = e_wen; t.e_wa = e_wa;
      tv.push_back(t);
   endtask

   task automatic idle();
      req_valid = '0; iss_valid = 0; iss_rd_en = 0; iss_rd = '0;
      rs1_addr = '0; rs2_addr = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      req_waddr = {5'd3, 5'd2, 5'd1};
      req_wdata = {64'h2222, 64'h1111, 64'h0000_0000_0000_1000};

      // requester addrs: r0=1 r1=2 r2=3
      //   v      iv ien rd  rs1 rs2  rdy    b1 b2 ir wen wa
      add(3'b111, 1, 1, 2,  0,  0,  3'b001, 0, 0, 1, 0, 0);
      add(3'b111, 0, 0, 0,  2,  0,  3'b010, 1, 0, 1, 1, 1);
      add(3'b111, 0, 1, 2,  2,  0,  3'b100, 1, 0, 0, 1, 2);
      add(3'b111, 0, 1, 2,  2,  0,  3'b001, 0, 0, 1, 1, 3);
      add(3'b111, 1, 1, 2,  0,  0,  3'b010, 0, 0, 1, 1, 1);
      add(3'b111, 0, 0, 0,  0,  2,  3'b100, 0, 1, 1, 1, 2);
      add(3'b000, 0, 0, 0,  0,  2,  3'b000, 0, 0, 1, 1, 3);
      add(3'b000, 0, 0, 0,  0,  0,  3'b000, 0, 0, 1, 0, 3);
      add(3'b110, 0, 0, 0,  0,  0,  3'b010, 0, 0, 1, 0, 3);
      add(3'b110, 0, 0, 0,  0,  0,  3'b100, 0, 0, 1, 1, 2);
      add(3'b001, 0, 0, 0,  0,  0,  3'b001, 0, 0, 1, 1, 3);
      add(3'b000, 0, 0, 0,  0,  0,  3'b000, 0, 0, 1, 1, 1);
      add(3'b101, 0, 0, 0,  0,  0,  3'b100, 0, 0, 1, 0, 1);
      add(3'b000, 0, 0, 0,  0,  0,  3'b000, 0, 0, 1, 1, 3);

      #12;
      chk("reset_rf_wen", rf_wen, 0);
      chk("reset_rf_waddr", rf_waddr, 0);
      chk("reset_rf_wdata", rf_wdata, 0);
      chk("reset_req_ready", req_ready, 0);
      chk("reset_iss_ready", iss_ready, 1);
      @(negedge clk); rst_n = 1'b1;

      // table: inputs change at negedge, checks 1 time unit later
      for (int i = 0; i < tv.size(); i++) begin
         if (i != 0) @(negedge clk);
         req_valid = tv[i].v; iss_valid = tv[i].iv; iss_rd_en = tv[i].ien; iss_rd = tv[i].ird;
         rs1_addr = tv[i].r1; rs2_addr = tv[i].r2;
         #1;
         chk($sformatf("v%0d_req_ready", i), req_ready, tv[i].e_rdy);
         chk($sformatf("v%0d_rs1_busy", i), rs1_busy, tv[i].e_b1);
         chk($sformatf("v%0d_rs2_busy", i), rs2_busy, tv[i].e_b2);
         chk($sformatf("v%0d_iss_ready", i), iss_ready, tv[i].e_ir);
         chk($sformatf("v%0d_rf_wen", i), rf_wen, tv[i].e_wen);
         chk($sformatf("v%0d_rf_waddr", i), rf_waddr, tv[i].e_wa);
      end

      // async reset mid-operation
      @(negedge clk);
      idle();
      req_valid = 3'b010; req_waddr[AW +: AW] = 5'd9;
      iss_valid = 1; iss_rd_en = 1; iss_rd = 5'd5;
      @(negedge clk);
      idle(); rs1_addr = 5'd5; iss_rd_en = 1; iss_rd = 5'd5;
      #1;
      chk("mid_rf_wen", rf_wen, 1);
      chk("mid_busy5", rs1_busy, 1);
      chk("mid_iss_ready", iss_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rf_wen", rf_wen, 0);
      chk("arst_rf_waddr", rf_waddr, 0);
      chk("arst_rf_wdata", rf_wdata, 0);
      chk("arst_busy5", rs1_busy, 0);
      chk("arst_iss_ready", iss_ready, 1);
      @(negedge clk); rst_n = 1'b1;

      // RAW: issue rd=7, writeback 0xDEAD from requester 1
      idle(); iss_valid = 1; iss_rd_en = 1; iss_rd = 5'd7;
      #1 chk("sb_iss_ready", iss_ready, 1);
      @(negedge clk);
      idle(); rs1_addr = 5'd7;
      req_valid = 3'b010; req_waddr[AW +: AW] = 5'd7; req_wdata[DW +: DW] = 64'hDEAD;
      #1;
      chk("sb_rs1_busy_set", rs1_busy, 1);
      chk("sb_req_ready", req_ready, 3'b010);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("sb_rf_wen", rf_wen, 1);
      chk("sb_rf_waddr", rf_waddr, 7);
      chk("sb_rf_wdata", rf_wdata, 64'hDEAD);
      chk("sb_busy_inflight", rs1_busy, 1);
      @(negedge clk); #1;
      chk("sb_busy_cleared", rs1_busy, 0);
      chk("sb_rf_wen_off", rf_wen, 0);
      chk("sb_wdata_hold", rf_wdata, 64'hDEAD);

      // WAW stall on rd=9
      @(negedge clk);
      idle(); iss_valid = 1; iss_rd_en = 1; iss_rd = 5'd9;
      @(negedge clk);
      idle(); iss_rd_en = 1; iss_rd = 5'd9;
      req_valid = 3'b001; req_waddr[0 +: AW] = 5'd9;
      #1 chk("waw_stall", iss_ready, 0);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("waw_stall_inflight", iss_ready, 0);
      chk("waw_rf_waddr", rf_waddr, 9);
      @(negedge clk); #1;
      chk("waw_release", iss_ready, 1);

      // set/clear collision on register 4
      @(negedge clk);
      idle(); req_valid = 3'b001; req_waddr[0 +: AW] = 5'd4;
      @(negedge clk);
      idle(); iss_valid = 1; iss_rd_en = 1; iss_rd = 5'd4;
      #1;
      chk("col_rf_wen", rf_wen, 1);
      chk("col_rf_waddr", rf_waddr, 4);
      chk("col_iss_ready", iss_ready, 1);
      @(negedge clk);
      idle(); rs1_addr = 5'd4;
      #1 chk("col_set_wins", rs1_busy, 1);

      // x0 write from requester 2
      @(negedge clk);
      idle(); rs1_addr = 5'd4;
      req_valid = 3'b100; req_waddr[2*AW +: AW] = 5'd0;
      #1 chk("x0_req_ready", req_ready, 3'b100);
      @(negedge clk);
      idle(); rs2_addr = 5'd4; iss_valid = 1; iss_rd_en = 1; iss_rd = 5'd0;
      #1;
      chk("x0_rf_wen", rf_wen, 0);
      chk("x0_busy4_kept", rs2_busy, 1);
      chk("x0_iss_ready", iss_ready, 1);
      @(negedge clk);
      idle(); rs2_addr = 5'd4;
      #1;
      chk("x0_busy0", rs1_busy, 0);
      chk("x0_busy4_still", rs2_busy, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ysyx_22040365_wb_arbiter.md
Name: ysyx_22040365_wb_arbiter

Overview:
Writeback controller for the single-write-port register file. Arbitrates NUM_REQ writeback sources (e.g. ALU, LSU, CSR) onto the one write port with round-robin fairness and valid/ready handshakes. Drives the regfile wen/waddr/wdata through registered outputs. Keeps a per-register busy scoreboard so issue logic can stall on RAW/WAW hazards against pending writes.

Parameters:
NUM_REQ, 3, number of writeback requesters (>=2)
ADDR_WIDTH, 5, register address width; NREG = 2**ADDR_WIDTH
DATA_WIDTH, 64, register data width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester write request
req_ready  output  NUM_REQ  per-requester grant; combinational, one-hot or zero
req_waddr  input  NUM_REQ*ADDR_WIDTH  packed dest addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data, same packing
rf_wen  output  1  regfile write enable (registered)
rf_waddr  output  ADDR_WIDTH  regfile write address (registered)
rf_wdata  output  DATA_WIDTH  regfile write data (registered)
iss_valid  input  1  issue stage presents an instruction
iss_rd_en  input  1  the instruction writes a destination register
iss_rd  input  ADDR_WIDTH  destination register of issuing instruction
rs1_addr  input  ADDR_WIDTH  source 1 to check
rs2_addr  input  ADDR_WIDTH  source 2 to check
rs1_busy  output  1  busy[rs1_addr], combinational
rs2_busy  output  1  busy[rs2_addr], combinational
iss_ready  output  1  low when iss_rd_en and busy[iss_rd] (WAW stall)

Behaviour:
- Reset (async, rst_n=0): rf_wen=0, rf_waddr=0, rf_wdata=0, all busy bits 0, rr pointer=0. Therefore req_ready=0 only if no req_valid; rs*_busy=0; iss_ready=1.
- Arbitration: combinational round-robin starting at pointer p. Grant the first i in order p, p+1, ..., p+NUM_REQ-1 (mod NUM_REQ) with req_valid[i]=1. At most one req_ready bit high; req_ready[i] never high without req_valid[i].
- Handshake: transfer occurs when req_valid[i]&req_ready[i]. Requesters hold valid/addr/data stable until ready. No transfer, no state change to pointer.
- Pointer: on a transfer from i, p <= (i+1) mod NUM_REQ. Otherwise p holds.
- Write port: on a transfer, next cycle rf_wen=1, rf_waddr/rf_wdata = granted addr/data (latency 1). With no transfer, rf_wen=0 and addr/data hold.
- x0: a transfer to address 0 is accepted (ready asserted) but rf_wen stays 0 and busy is untouched.
- Scoreboard set: on edge where iss_valid & iss_rd_en & iss_ready & iss_rd!=0, busy[iss_rd] <= 1.
- Scoreboard clear: on edge where rf_wen=1, busy[rf_waddr] <= 0. The clear happens on the same edge the regfile writes, so busy=0 is visible exactly when the new value is readable.
- Simultaneous set and clear of the same register on one edge: set wins (busy stays 1).
- busy[0] is constant 0.
- rs1_busy/rs2_busy/iss_ready depend on the current busy state only. There is no bypass of a write in flight this cycle.
- Back-to-back: one transfer per cycle sustained. rf_wen may stay high every cycle.

Test Plan:
- Reset mid-operation: busy[5]=1, rf_wen=1, rst_n pulsed low asynchronously -> all outputs and busy cleared immediately, iss_ready=1.
- Round-robin, all req_valid=3'b111 held 6 cycles, p=0 -> grants 0,1,2,0,1,2; rf_waddr sequence follows each requester's address with 1-cycle lag.
- Scoreboard: issue rd=7, then rs1_addr=7 -> rs1_busy=1. Requester 1 writes addr 7 data 0xDEAD -> busy cleared on the rf_wen edge; next cycle rs1_busy=0 and the regfile reads 0xDEAD.
- WAW stall: busy[9]=1, iss_rd_en=1, iss_rd=9 -> iss_ready=0. After the writeback to 9 completes, iss_ready=1.
- Set/clear collision: rf_wen=1, rf_waddr=4, same-edge issue rd=4 -> busy[4]=1 afterwards.
- x0: requester 2 writes addr 0 -> req_ready[2]=1, next cycle rf_wen=0, busy unchanged. Issue rd=0 -> rs1_busy for addr 0 stays 0.
